divisor: RTL and testbench



---
 rtl/divisor_pkg.sv | 32 +++
 rtl/divisor_paso_division.sv | 37 +++
 rtl/divisor.sv | 150 +++++++++++++++
 tb/tb_divisor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divisor_pkg
// Description : Shared definitions for the sequential restoring divider:
//               default operand width, FSM state encoding and the quotient
//               returned on divide-by-zero.
// Options     : DIVISOR_SIGNED_EN (see divisor.sv)
// Revision    : 1.0  initial release
// ============================================================================
package divisor_pkg;

    // Default operand width for dividend, divisor, quotient and remainder
    localparam int DIV_N = 4;

    // State encoding, explicit 2-bit width
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        ITER = ST_ITER,
        DONE = ST_DONE
    } state_t;

    // Divide-by-zero quotient: all ones, sliced to the operand width by users
    localparam logic [31:0] DIV_DZ_QUOT = 32'hFFFF_FFFF;

endpackage : divisor_pkg
`default_nettype wire

// File: rtl/divisor_paso_division.sv
`default_nettype none
// ============================================================================
// Module      : paso_division
// Description : One restoring-division step, purely combinational.
//               Shifts {A,Q} left by one, trial-subtracts M from the shifted
//               partial remainder and keeps or restores it, shifting the
//               resulting quotient bit into Q[0].
// Revision    : 1.0  initial release
// ============================================================================
module paso_division
    import divisor_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   i_a,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_m,
    output logic [N:0]   o_a,
    output logic [N-1:0] o_q
);

    logic [N:0]   w_a_sh;
    logic [N+1:0] w_diff;
    logic         w_neg;

    // The partial remainder stays below M, so A[N] is zero on entry; the full
    // {A,Q[N-1]} is still fed to the subtractor so the borrow lands in the MSB.
    assign w_a_sh = {i_a[N-1:0], i_q[N-1]};
    assign w_diff = {i_a, i_q[N-1]} - {2'b00, i_m};
    assign w_neg  = w_diff[N+1];

    // Keep the difference when non-negative, otherwise restore the shifted value
    assign o_a = w_neg ? w_a_sh : w_diff[N:0];
    assign o_q = {i_q[N-2:0], ~w_neg};

endmodule : paso_division
`default_nettype wire

// File: rtl/divisor.sv
`default_nettype none
// ============================================================================
// Module      : divisor
// Description : Sequential restoring divider with init/done handshake.
//               IDLE -> LOAD -> ITER (N cycles) -> DONE -> IDLE.
//               Divide-by-zero skips ITER and returns C=all ones, R=DV, dz=1.
// Options     : DIVISOR_SIGNED_EN - two's-complement operands, truncating
//               division (remainder takes the dividend's sign).
// Revision    : 1.0  initial release
// ============================================================================
module divisor
    import divisor_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic [N-1:0] DV,
    input  logic [N-1:0] DR,
    output logic         done,
    output logic         busy,
    output logic [N-1:0] C,
    output logic [N-1:0] R,
    output logic         dz
);

    localparam int CW = $clog2(N + 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_m;
    logic [CW-1:0]  r_cnt;

    logic [N:0]     w_a_step;
    logic [N-1:0]   w_q_step;
    logic [N-1:0]   w_dv_mag;
    logic [N-1:0]   w_dr_mag;
    logic [N-1:0]   w_c_final;
    logic [N-1:0]   w_r_final;
    logic           w_last;

    assign w_last = (r_cnt == CW'(1));

`ifdef DIVISOR_SIGNED_EN
    logic r_sign_q;
    logic r_sign_r;

    // Operands enter the iteration as magnitudes; -MIN still fits as unsigned
    assign w_dv_mag = DV[N-1] ? -DV : DV;
    assign w_dr_mag = DR[N-1] ? -DR : DR;

    // Sign correction folded into the DONE entry. MIN/-1 yields magnitude
    // 2^(N-1) with a positive sign, which reads back as MIN.
    assign w_c_final = r_sign_q ? -w_q_step : w_q_step;
    assign w_r_final = r_sign_r ? -w_a_step[N-1:0] : w_a_step[N-1:0];

    // Record the result signs at LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (r_state == LOAD) begin
            r_sign_q <= DV[N-1] ^ DR[N-1];
            r_sign_r <= DV[N-1];
        end
    end
`else
    assign w_dv_mag  = DV;
    assign w_dr_mag  = DR;
    assign w_c_final = w_q_step;
    assign w_r_final = w_a_step[N-1:0];
`endif

    paso_division #(.N(N)) u_paso (
        .i_a (r_a),
        .i_q (r_q),
        .i_m (r_m),
        .o_a (w_a_step),
        .o_q (w_q_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; init is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = init ? LOAD : IDLE;
            LOAD:    w_state_nxt = (DR == '0) ? DONE : ITER;
            ITER:    w_state_nxt = w_last ? DONE : ITER;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign done = (r_state == DONE);
    assign busy = (r_state != IDLE);

    // Datapath: operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            C     <= '0;
            R     <= '0;
            dz    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_a   <= '0;
                    r_q   <= w_dv_mag;
                    r_m   <= w_dr_mag;
                    r_cnt <= CW'(N);
                    if (DR == '0) begin
                        C  <= DIV_DZ_QUOT[N-1:0];
                        R  <= DV;
                        dz <= 1'b1;
                    end else begin
                        dz <= 1'b0;
                    end
                end
                ITER: begin
                    r_a   <= w_a_step;
                    r_q   <= w_q_step;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        C <= w_c_final;
                        R <= w_r_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : divisor
`default_nettype wire

// File: tb/tb_divisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor
// Description : Self-checking bench for divisor: reset values, directed
//               divisions with hand-computed results, latency, handshake
//               behaviour, mid-operation reset and a full N=4 sweep.
// Options     : DIVISOR_SIGNED_EN selects signed expectations
// Revision    : 1.0  initial release
// ============================================================================
module tb_divisor;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         init;
    logic [N-1:0] DV;
    logic [N-1:0] DR;
    logic         done;
    logic         busy;
    logic [N-1:0] C;
    logic [N-1:0] R;
    logic         dz;

    int n_checks;
    int n_errs;

    divisor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (init),
        .DV    (DV),
        .DR    (DR),
        .done  (done),
        .busy  (busy),
        .C     (C),
        .R     (R),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model for the sweep
    task automatic model(input logic [N-1:0] dv, input logic [N-1:0] dr,
                         output logic [N-1:0] c, output logic [N-1:0] r, output logic d);
`ifdef DIVISOR_SIGNED_EN
        int a;
        int b;
        a = $signed(dv);
        b = $signed(dr);
        if (b == 0) begin
            c = 4'hF; r = dv; d = 1'b1;
        end else begin
            c = 4'(a / b); r = 4'(a % b); d = 1'b0;
        end
`else
        if (dr == 0) begin
            c = 4'hF; r = dv; d = 1'b1;
        end else begin
            c = dv / dr; r = dv % dr; d = 1'b0;
        end
`endif
    endtask

    // Runs one operation starting at cycle 0 (called #1 after an edge, in IDLE).
    // mode 0: plain; 1: re-pulse init in ITER and change DV/DR after LOAD;
    // 2: quiet (no per-cycle busy checks).
    task automatic run_op(input logic [N-1:0] dv, input logic [N-1:0] dr,
                          input logic [N-1:0] exp_c, input logic [N-1:0] exp_r,
                          input logic exp_dz, input int mode, input string tag);
        int  cyc;
        int  lat;
        bit  seen;
        lat  = (dr == 0) ? 2 : N + 2;
        DV   = dv;
        DR   = dr;
        init = 1'b1;
        if (mode != 2) check_eq({tag, "_busy0"}, busy, 0);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) init = 1'b0;
            if (mode == 1 && cyc == 2) begin DV = ~dv; DR = dr + 4'd1; end
            if (mode == 1 && cyc == 3) init = 1'b1;
            if (mode == 1 && cyc == 4) init = 1'b0;
            if (mode != 2) check_eq($sformatf("%s_busy%0d", tag, cyc), busy, 1);
            if (done) seen = 1;
        end
        init = 1'b0;
        check_eq({tag, "_lat"}, cyc, lat);
        check_eq({tag, "_C"}, C, exp_c);
        check_eq({tag, "_R"}, R, exp_r);
        check_eq({tag, "_dz"}, dz, exp_dz);
`ifndef DIVISOR_SIGNED_EN
        if (mode == 2 && dr != 0) begin
            check_eq({tag, "_inv"}, 32'(C) * 32'(dr) + 32'(R), 32'(dv));
            check_eq({tag, "_rlt"}, (R < dr), 1);
        end
`endif
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        if (mode != 2) check_eq({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [N-1:0] mc;
        logic [N-1:0] mr;
        logic         md;
        int           ndone;
        int           first;
        int           prev;
        bit           bad_gap;
        bit           any_done;
        bit           any_busy;
        int           k;

        n_checks = 0;
        n_errs   = 0;
        rst_n    = 1'b0;
        init     = 1'b0;
        DV       = '0;
        DR       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_C",    C, 0);
        check_eq("rst_R",    R, 0);
        check_eq("rst_dz",   dz, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DIVISOR_SIGNED_EN
        run_op(4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 0, "s_m7_2");
        run_op(4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 0, "s_7_m2");
        run_op(4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 0, "s_m8_m1");
        run_op(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 0, "s_7_2");
        run_op(4'h9, 4'h0, 4'hF, 4'h9, 1'b1, 0, "dz_9_0");
        run_op(4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 0, "s_6_3");
        run_op(4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1, "hs_poke");
`else
        run_op(4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 0, "u_13_4");
        run_op(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 0, "u_15_1");
        run_op(4'd5,  4'd7,  4'd0,  4'd5, 1'b0, 0, "u_5_7");
        run_op(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 0, "u_15_15");
        run_op(4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 0, "dz_9_0");
        run_op(4'd9,  4'd3,  4'd3,  4'd0, 1'b0, 0, "u_9_3");
        run_op(4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 1, "hs_poke");
`endif

        // Reset during the third ITER cycle: everything clears, no done pulse
        DV = 4'd7; DR = 4'd2; init = 1'b1;
        @(posedge clk); #1; init = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_eq("mrst_C",    C, 0);
        check_eq("mrst_R",    R, 0);
        check_eq("mrst_dz",   dz, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_done", done, 0);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        any_done = 0;
        any_busy = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) any_done = 1;
            if (busy) any_busy = 1;
        end
        check_eq("mrst_no_done", any_done, 0);
        check_eq("mrst_no_busy", any_busy, 0);
        run_op(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 0, "mrst_after");

        // init held high: back-to-back operations, done every 7 cycles
        DV = 4'd7; DR = 4'd2; init = 1'b1;
        ndone = 0; first = 0; prev = 0; bad_gap = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
                if (prev != 0 && cyc - prev != 7) bad_gap = 1;
                prev = cyc;
                check_eq($sformatf("held_C%0d", cyc), C, 3);
                check_eq($sformatf("held_R%0d", cyc), R, 1);
            end
        end
        check_eq("held_first", first, 6);
        check_eq("held_count", ndone, 5);
        check_eq("held_gap",   bad_gap, 0);
        init = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("held_drain", busy, 0);

        // Full sweep of all operand pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(4'(a), 4'(b), mc, mr, md);
                run_op(4'(a), 4'(b), mc, mr, md, 2, $sformatf("sw_%0d_%0d", a, b));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_divisor
`default_nettype wire
